// File: rtl/lv_flt_dgl.sv
// Purpose : N-channel fault deglitch/latch: 2-flop sync, programmable assert/deassert debounce, live + sticky status.
// Latency : raw held stable -> flt_sts_o changes after th+2 core clock edges (th = dgl_th_i, 0 treated as 1).
// Backpr. : none; free-running status block, all outputs valid every cycle.
//
// Ports:
//   clk, rst_n        clock and async active-low reset
//   flt_raw_i         raw async fault inputs (active high), one per channel
//   flt_en_i          per-channel enable; 0 forces the channel idle and clears its status
//   dgl_th_i          shared debounce threshold in cycles (0 behaves as 1)
//   flt_clr_i         W1C pulse for sticky status (ignored while the live fault is still present)
//   flt_sts_o         debounced live status
//   flt_lat_o         sticky status, set on each debounced rising edge
//   flt_rise_o        one-cycle pulse on flt_sts_o 0->1
//   flt_evt_cnt_o     per-channel saturating event counters, ch0 in LSBs (LV_FLT_CNT_EN only)
//   flt_any_o         OR of flt_lat_o
//
// Optional feature macro: LV_FLT_CNT_EN adds the event counters and the flt_evt_cnt_o port.

`default_nettype none

module lv_flt_dgl #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 8,
    parameter int EVT_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH_NUM-1:0]         flt_raw_i,
    input  logic [CH_NUM-1:0]         flt_en_i,
    input  logic [CNT_W-1:0]          dgl_th_i,
    input  logic [CH_NUM-1:0]         flt_clr_i,
    output logic [CH_NUM-1:0]         flt_sts_o,
    output logic [CH_NUM-1:0]         flt_lat_o,
    output logic [CH_NUM-1:0]         flt_rise_o,
`ifdef LV_FLT_CNT_EN
    output logic [CH_NUM*EVT_W-1:0]   flt_evt_cnt_o,
`endif
    output logic                      flt_any_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_FAULT,
        ST_REL
    } st_t;

    // Elaboration-time sanity check on the parameter set.
    if (CH_NUM < 1 || CNT_W < 1 || EVT_W < 1) begin : g_param_chk
        $error("lv_flt_dgl: CH_NUM, CNT_W and EVT_W must all be >= 1");
    end

    logic [CH_NUM-1:0] sync1_q;
    logic [CH_NUM-1:0] sync2_q;
    logic [CNT_W-1:0]  th_eff;
    logic              th_one;

    // The synchroniser keeps running even on disabled channels so re-enable sees a settled value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= flt_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign th_eff = (dgl_th_i == '0) ? CNT_W'(1) : dgl_th_i;
    assign th_one = (th_eff == CNT_W'(1));

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        st_t              st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
        logic [CNT_W:0]   cnt_p1;
        logic             sts_q, sts_d;
        logic             rise_q, rise_d;
        logic             lat_q, lat_d;
        logic             s, reach, clr_ok;

        assign s       = sync2_q[c];
        // One extra bit so the >= compare is exact even when cnt sits at all-ones.
        assign cnt_p1  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        assign reach   = (cnt_p1 >= {1'b0, th_eff});
        assign cnt_sat = cnt_p1[CNT_W] ? cnt_q : cnt_p1[CNT_W-1:0];
        // Sticky clear only takes effect once the live fault has gone away.
        assign clr_ok  = flt_clr_i[c] & ~sts_q;

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            sts_d  = sts_q;
            rise_d = 1'b0;
            if (!flt_en_i[c]) begin
                st_d  = ST_IDLE;
                cnt_d = '0;
                sts_d = 1'b0;
            end else begin
                unique case (st_q)
                    ST_IDLE: begin
                        cnt_d = '0;
                        sts_d = 1'b0;
                        if (s) begin
                            if (th_one) begin
                                st_d   = ST_FAULT;
                                sts_d  = 1'b1;
                                rise_d = 1'b1;
                            end else begin
                                st_d  = ST_ARM;
                                cnt_d = CNT_W'(1);
                            end
                        end
                    end
                    ST_ARM: begin
                        if (!s) begin
                            st_d  = ST_IDLE;
                            cnt_d = '0;
                        end else if (reach) begin
                            st_d   = ST_FAULT;
                            sts_d  = 1'b1;
                            rise_d = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_sat;
                        end
                    end
                    ST_FAULT: begin
                        cnt_d = '0;
                        sts_d = 1'b1;
                        if (!s) begin
                            if (th_one) begin
                                st_d  = ST_IDLE;
                                sts_d = 1'b0;
                            end else begin
                                st_d  = ST_REL;
                                cnt_d = CNT_W'(1);
                            end
                        end
                    end
                    ST_REL: begin
                        if (s) begin
                            st_d  = ST_FAULT;
                            cnt_d = '0;
                        end else if (reach) begin
                            st_d  = ST_IDLE;
                            sts_d = 1'b0;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_sat;
                        end
                    end
                    default: begin
                        st_d  = ST_IDLE;
                        cnt_d = '0;
                        sts_d = 1'b0;
                    end
                endcase
            end
        end

        // Set wins over a coincident clear; a disable drops the sticky bit as well.
        always_comb begin
            lat_d = lat_q;
            if (!flt_en_i[c]) begin
                lat_d = 1'b0;
            end else if (rise_d) begin
                lat_d = 1'b1;
            end else if (clr_ok) begin
                lat_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= ST_IDLE;
                cnt_q  <= '0;
                sts_q  <= 1'b0;
                rise_q <= 1'b0;
                lat_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                sts_q  <= sts_d;
                rise_q <= rise_d;
                lat_q  <= lat_d;
            end
        end

        assign flt_sts_o[c]  = sts_q;
        assign flt_lat_o[c]  = lat_q;
        assign flt_rise_o[c] = rise_q;

`ifdef LV_FLT_CNT_EN
        logic [EVT_W-1:0] evt_q;

        // Counts debounced rising edges, holds at all-ones; clear follows the sticky-bit rule.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                evt_q <= '0;
            end else if (rise_d) begin
                if (evt_q != '1) begin
                    evt_q <= evt_q + EVT_W'(1);
                end
            end else if (clr_ok) begin
                evt_q <= '0;
            end
        end

        assign flt_evt_cnt_o[c*EVT_W +: EVT_W] = evt_q;
`endif
    end

    assign flt_any_o = |flt_lat_o;

endmodule

`default_nettype wire

// File: tb/tb_lv_flt_dgl.sv
`timescale 1ns/1ps

module tb_lv_flt_dgl;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int EW = 4;
    localparam int EVT_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] flt_raw, flt_en, flt_clr;
    logic [CW-1:0] dgl_th;
    logic [CH-1:0] flt_sts, flt_lat, flt_rise;
    logic          flt_any;
`ifdef LV_FLT_CNT_EN
    logic [CH*EW-1:0] flt_evt_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lv_flt_dgl #(.CH_NUM(CH), .CNT_W(CW), .EVT_W(EW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flt_raw_i     (flt_raw),
        .flt_en_i      (flt_en),
        .dgl_th_i      (dgl_th),
        .flt_clr_i     (flt_clr),
        .flt_sts_o     (flt_sts),
        .flt_lat_o     (flt_lat),
        .flt_rise_o    (flt_rise),
`ifdef LV_FLT_CNT_EN
        .flt_evt_cnt_o (flt_evt_cnt),
`endif
        .flt_any_o     (flt_any)
    );

    // Reference model: a channel's live status flips once the synchronised input has
    // disagreed with it for th consecutive samples; the run restarts on any agreement.
    logic [CH-1:0] m_s1, m_s2, m_sts, m_lat, m_rise;
    int            m_run [CH];
    int            m_evt [CH];

    always @(posedge clk or negedge rst_n) begin
        int   th;
        logic old_sts;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_sts = '0; m_lat = '0; m_rise = '0;
            for (int c = 0; c < CH; c++) begin
                m_run[c] = 0;
                m_evt[c] = 0;
            end
        end else begin
            th = (dgl_th == 0) ? 1 : int'(dgl_th);
            for (int c = 0; c < CH; c++) begin
                old_sts   = m_sts[c];
                m_rise[c] = 1'b0;
                if (!flt_en[c]) begin
                    m_sts[c] = 1'b0;
                    m_run[c] = 0;
                    m_lat[c] = 1'b0;
                end else begin
                    m_run[c] = (m_s2[c] != m_sts[c]) ? m_run[c] + 1 : 0;
                    if (m_run[c] >= th) begin
                        m_sts[c]  = ~m_sts[c];
                        m_run[c]  = 0;
                        m_rise[c] = m_sts[c];
                    end
                    if (m_rise[c]) m_lat[c] = 1'b1;
                    else if (flt_clr[c] && !old_sts) m_lat[c] = 1'b0;
                end
                if (m_rise[c]) begin
                    if (m_evt[c] < EVT_MAX) m_evt[c] = m_evt[c] + 1;
                end else if (flt_clr[c] && !old_sts) begin
                    m_evt[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = flt_raw;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_model();
        chk("rnd_sts",  64'(flt_sts),  64'(m_sts));
        chk("rnd_lat",  64'(flt_lat),  64'(m_lat));
        chk("rnd_rise", 64'(flt_rise), 64'(m_rise));
        chk("rnd_any",  64'(flt_any),  64'(|m_lat));
`ifdef LV_FLT_CNT_EN
        for (int c = 0; c < CH; c++)
            chk("rnd_evt", 64'(flt_evt_cnt[c*EW +: EW]), 64'(m_evt[c]));
`endif
    endtask

    typedef struct {
        logic [CH-1:0] raw;
        logic [CH-1:0] clr;
        logic [CW-1:0] th;
        logic [CH-1:0] sts;
        logic [CH-1:0] lat;
        logic [CH-1:0] rise;
    } vec_t;

    function automatic vec_t mk(input logic [CH-1:0] raw, input logic [CH-1:0] clr,
                                input logic [CW-1:0] th, input logic [CH-1:0] sts,
                                input logic [CH-1:0] lat, input logic [CH-1:0] rise);
        vec_t v;
        v.raw = raw; v.clr = clr; v.th = th; v.sts = sts; v.lat = lat; v.rise = rise;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];

        // th=4: ch0 high 10 cycles (faults at edge 6), ch1 high 3 cycles (rejected);
        // clr while faulted is ignored; release after 4+2 edges; clr then clears.
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(4'h3, 4'h0, 8'd4, 4'h0, 4'h0, 4'h0));
        for (int i = 0; i < 2; i++)  tbl.push_back(mk(4'h1, 4'h0, 8'd4, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(4'h1, 4'h0, 8'd4, 4'h1, 4'h1, 4'h1));
        tbl.push_back(mk(4'h1, 4'h0, 8'd4, 4'h1, 4'h1, 4'h0));
        tbl.push_back(mk(4'h1, 4'h1, 8'd4, 4'h1, 4'h1, 4'h0));
        for (int i = 0; i < 2; i++)  tbl.push_back(mk(4'h1, 4'h0, 8'd4, 4'h1, 4'h1, 4'h0));
        for (int i = 0; i < 5; i++)  tbl.push_back(mk(4'h0, 4'h0, 8'd4, 4'h1, 4'h1, 4'h0));
        tbl.push_back(mk(4'h0, 4'h0, 8'd4, 4'h0, 4'h1, 4'h0));
        tbl.push_back(mk(4'h0, 4'h1, 8'd4, 4'h0, 4'h0, 4'h0));
        // th=0 acts as 1: 2-cycle pulse faults at edge 3; clr on the set edge loses.
        for (int i = 0; i < 2; i++)  tbl.push_back(mk(4'h1, 4'h0, 8'd0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(4'h0, 4'h1, 8'd0, 4'h1, 4'h1, 4'h1));
        tbl.push_back(mk(4'h0, 4'h1, 8'd0, 4'h1, 4'h1, 4'h0));
        tbl.push_back(mk(4'h0, 4'h0, 8'd0, 4'h0, 4'h1, 4'h0));
        tbl.push_back(mk(4'h0, 4'h1, 8'd0, 4'h0, 4'h0, 4'h0));

        rst_n   = 1'b0;
        flt_raw = '0;
        flt_en  = '1;
        flt_clr = '0;
        dgl_th  = 8'd4;
        step(2);
        chk("rst_sts",  64'(flt_sts),  64'h0);
        chk("rst_lat",  64'(flt_lat),  64'h0);
        chk("rst_rise", 64'(flt_rise), 64'h0);
        chk("rst_any",  64'(flt_any),  64'h0);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            flt_raw = tbl[k].raw;
            flt_clr = tbl[k].clr;
            dgl_th  = tbl[k].th;
            step(1);
            chk($sformatf("tbl%0d_sts", k),  64'(flt_sts),  64'(tbl[k].sts));
            chk($sformatf("tbl%0d_lat", k),  64'(flt_lat),  64'(tbl[k].lat));
            chk($sformatf("tbl%0d_rise", k), 64'(flt_rise), 64'(tbl[k].rise));
            chk($sformatf("tbl%0d_any", k),  64'(flt_any),  64'(|tbl[k].lat));
        end
        flt_clr = '0;

        // Disable ch2 while faulted, then re-enable with th=8: status after 10 edges.
        dgl_th  = 8'd0;
        flt_raw = 4'h4;
        step(3);
        chk("en_pre_sts2", 64'(flt_sts[2]), 64'h1);
        chk("en_pre_lat2", 64'(flt_lat[2]), 64'h1);
        flt_en  = 4'hB;
        flt_raw = 4'h0;
        step(1);
        chk("en_off_sts2", 64'(flt_sts[2]), 64'h0);
        chk("en_off_lat2", 64'(flt_lat[2]), 64'h0);
        step(2);
        flt_en  = 4'hF;
        flt_raw = 4'h4;
        dgl_th  = 8'd8;
        step(9);
        chk("en_re_sts2_e9",   64'(flt_sts[2]),  64'h0);
        step(1);
        chk("en_re_sts2_e10",  64'(flt_sts[2]),  64'h1);
        chk("en_re_rise2_e10", 64'(flt_rise[2]), 64'h1);
        flt_raw = 4'h0;
        step(12);

        // 20 debounced events on ch3; counter holds at its maximum; clear after release.
        dgl_th = 8'd0;
        for (int e = 0; e < 20; e++) begin
            flt_raw = 4'h8;
            step(2);
            flt_raw = 4'h0;
            step(2);
        end
        step(4);
        chk("evt_lat3", 64'(flt_lat[3]), 64'h1);
`ifdef LV_FLT_CNT_EN
        chk("evt_cnt3_sat", 64'(flt_evt_cnt[3*EW +: EW]), 64'(EVT_MAX));
`endif
        flt_clr = 4'h8;
        step(1);
        flt_clr = 4'h0;
        chk("evt_clr_lat3", 64'(flt_lat[3]), 64'h0);
`ifdef LV_FLT_CNT_EN
        chk("evt_clr_cnt3", 64'(flt_evt_cnt[3*EW +: EW]), 64'h0);
`endif

        // Async reset while ch0 is mid-ARM; the partial count must not survive.
        dgl_th  = 8'd8;
        flt_raw = 4'h1;
        step(5);
        chk("arst_pre_any", 64'(flt_any), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sts",  64'(flt_sts),  64'h0);
        chk("arst_lat",  64'(flt_lat),  64'h0);
        chk("arst_rise", 64'(flt_rise), 64'h0);
        chk("arst_any",  64'(flt_any),  64'h0);
`ifdef LV_FLT_CNT_EN
        chk("arst_evt", 64'(flt_evt_cnt), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(9);
        chk("arst_post_sts0_e9",  64'(flt_sts[0]), 64'h0);
        step(1);
        chk("arst_post_sts0_e10", 64'(flt_sts[0]), 64'h1);

        // Randomised traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk_model();
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) flt_raw[c] = ~flt_raw[c];
                flt_en[c]  = ($urandom_range(0, 39) != 0);
                flt_clr[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 49) == 0) dgl_th = CW'($urandom_range(0, 6));
            step(1);
        end
        chk_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
